// File: rtl/player_sequencer_if.sv
// Signal bundle between the game-flow sequencer and the input/timing and
// player/collision side; master is the sequencer, slave is everything around it.
interface player_sequencer_if;
    logic        frame_tick;
    logic        start_btn;
    logic        jump_btn;
    logic        goal_hit;
    logic [31:0] player_state;
    logic        player_step;
    logic        player_load;
    logic [31:0] init_state;
    logic        jump_r;
    logic [1:0]  level;
    logic [1:0]  lives;
    logic [2:0]  game_state;

    modport master (
        input  frame_tick, start_btn, jump_btn, goal_hit, player_state,
        output player_step, player_load, init_state, jump_r, level, lives, game_state
    );

    modport slave (
        output frame_tick, start_btn, jump_btn, goal_hit, player_state,
        input  player_step, player_load, init_state, jump_r, level, lives, game_state
    );
endinterface

// File: rtl/player_sequencer.sv
// Game-flow controller: turns frame ticks into single-cycle player strobes, loads
// per-level start state and walks title/play/freeze/clear/over/win.
module player_sequencer #(
    parameter int unsigned NUM_LEVELS    = 4,
    parameter int unsigned LIVES         = 3,
    parameter logic [9:0]  DEATH_Y       = 10'd515,
    parameter int unsigned FREEZE_FRAMES = 60
) (
    input  logic               sim_clk,
    input  logic               reset_n,
    player_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PLAY    = 3'd2,
        DYING   = 3'd3,
        CLEARED = 3'd4,
        OVER    = 3'd5,
        WON     = 3'd6
    } game_state_e;

    localparam logic [1:0] LAST_LEVEL_C  = 2'(NUM_LEVELS - 1);
    localparam logic [1:0] START_LIVES_C = 2'(LIVES);
    localparam logic [7:0] FREEZE_LEN_C  = 8'(FREEZE_FRAMES);

    // Start vector: fixed spawn point, moving right/down, speed rising with level.
    function automatic logic [31:0] init_vector(input logic [1:0] lvl);
        return {10'd176, 10'd99, 5'd4 + {3'b000, lvl}, 5'd0, 1'b1, 1'b0};
    endfunction

    game_state_e state_r;
    logic [1:0]  level_r;
    logic [1:0]  lives_r;
    logic [7:0]  freeze_cnt_r;
    logic        jump_latch_r;
    logic        start_prev_r;
    logic        jump_prev_r;
    logic        player_step_r;
    logic        player_load_r;
    logic        jump_req_r;

    logic        start_edge_s;
    logic        jump_edge_s;
    logic        dead_s;
    logic        freeze_done_s;

    assign start_edge_s  = bus.start_btn & ~start_prev_r;
    assign jump_edge_s   = bus.jump_btn & ~jump_prev_r;
    assign dead_s        = (bus.player_state[21:12] >= DEATH_Y);
    assign freeze_done_s = ((freeze_cnt_r + 8'd1) == FREEZE_LEN_C);

    // Game-flow FSM with all strobes, counters and the jump latch registered.
    always_ff @(posedge sim_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            level_r       <= 2'd0;
            lives_r       <= START_LIVES_C;
            freeze_cnt_r  <= 8'd0;
            jump_latch_r  <= 1'b0;
            start_prev_r  <= 1'b0;
            jump_prev_r   <= 1'b0;
            player_step_r <= 1'b0;
            player_load_r <= 1'b1;
            jump_req_r    <= 1'b0;
        end else begin
            start_prev_r  <= bus.start_btn;
            jump_prev_r   <= bus.jump_btn;
            player_step_r <= 1'b0;
            player_load_r <= 1'b1;
            jump_req_r    <= 1'b0;
            jump_latch_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_edge_s) state_r <= LOAD;
                    else              state_r <= IDLE;
                end
                LOAD: begin
                    if (bus.frame_tick) begin
                        player_step_r <= 1'b1;
                        state_r       <= PLAY;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                PLAY: begin
                    player_load_r <= 1'b0;
                    if (bus.frame_tick && dead_s) begin
                        player_load_r <= 1'b1;
                        state_r       <= DYING;
                    end else if (bus.frame_tick && bus.goal_hit) begin
                        player_load_r <= 1'b1;
                        state_r       <= CLEARED;
                    end else if (bus.frame_tick) begin
                        // a press landing on the consuming step is kept for the next one
                        player_step_r <= 1'b1;
                        jump_req_r    <= jump_latch_r;
                        jump_latch_r  <= jump_edge_s;
                    end else begin
                        jump_latch_r  <= jump_latch_r | jump_edge_s;
                    end
                end
                DYING: begin
                    if (bus.frame_tick && freeze_done_s) begin
                        freeze_cnt_r <= 8'd0;
                        if (lives_r <= 2'd1) begin
                            lives_r <= 2'd0;
                            state_r <= OVER;
                        end else begin
                            lives_r <= lives_r - 2'd1;
                            state_r <= LOAD;
                        end
                    end else if (bus.frame_tick) begin
                        freeze_cnt_r <= freeze_cnt_r + 8'd1;
                    end else begin
                        freeze_cnt_r <= freeze_cnt_r;
                    end
                end
                CLEARED: begin
                    if (bus.frame_tick && freeze_done_s) begin
                        freeze_cnt_r <= 8'd0;
                        if (level_r == LAST_LEVEL_C) begin
                            state_r <= WON;
                        end else begin
                            level_r <= level_r + 2'd1;
                            state_r <= LOAD;
                        end
                    end else if (bus.frame_tick) begin
                        freeze_cnt_r <= freeze_cnt_r + 8'd1;
                    end else begin
                        freeze_cnt_r <= freeze_cnt_r;
                    end
                end
                OVER, WON: begin
                    if (start_edge_s) begin
                        level_r <= 2'd0;
                        lives_r <= START_LIVES_C;
                        state_r <= LOAD;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.player_step = player_step_r;
    assign bus.player_load = player_load_r;
    assign bus.jump_r      = jump_req_r;
    assign bus.level       = level_r;
    assign bus.lives       = lives_r;
    assign bus.game_state  = state_r;
    assign bus.init_state  = init_vector(level_r);
endmodule

// File: tb/tb_player_sequencer.sv
// Bench for player_sequencer: a frame-level game model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_player_sequencer;
    localparam int FREEZE = 60;
    localparam logic [31:0] ALIVE_STATE = 32'h2C06_3202;

    typedef struct packed {
        int state;
        int level;
        int lives;
        int freeze;
        bit pend;
        bit step;
        bit load;
        bit jump;
    } ms_t;

    logic sim_clk;
    logic reset_n;
    player_sequencer_if bus();

    player_sequencer dut (
        .sim_clk (sim_clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int errors = 0;
    int checks = 0;
    ms_t m;
    bit m_sprev, m_jprev;

    initial sim_clk = 1'b0;
    always #5 sim_clk = ~sim_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ms_t model_reset();
        ms_t r;
        r.state = 0; r.level = 0; r.lives = 3; r.freeze = 0;
        r.pend = 1'b0; r.step = 1'b0; r.load = 1'b1; r.jump = 1'b0;
        return r;
    endfunction

    // One clock of the game rules: states 0 idle,1 load,2 play,3 dying,4 cleared,5 over,6 won.
    function automatic ms_t model_next(input ms_t c, input bit tick, input bit se,
                                       input bit je, input bit dead, input bit goal);
        ms_t n;
        n = c;
        n.step = 1'b0; n.jump = 1'b0; n.load = 1'b1;
        if (c.state == 0) begin
            if (se) n.state = 1;
        end else if (c.state == 1) begin
            if (tick) begin n.step = 1'b1; n.state = 2; end
        end else if (c.state == 2) begin
            if (je) n.pend = 1'b1;
            if (tick && dead) n.state = 3;
            else if (tick && goal) n.state = 4;
            else if (tick) begin
                n.step = 1'b1; n.load = 1'b0; n.jump = c.pend; n.pend = je;
            end
        end else if (c.state == 3 || c.state == 4) begin
            if (tick) begin
                n.freeze = c.freeze + 1;
                if (n.freeze == FREEZE) begin
                    n.freeze = 0;
                    if (c.state == 3) begin
                        n.lives = (c.lives > 0) ? c.lives - 1 : 0;
                        n.state = (n.lives == 0) ? 5 : 1;
                    end else if (c.level == 3) begin
                        n.state = 6;
                    end else begin
                        n.level = c.level + 1;
                        n.state = 1;
                    end
                end
            end
        end else begin
            if (se) begin n.level = 0; n.lives = 3; n.state = 1; end
        end
        if (n.state != 2) n.pend = 1'b0;
        return n;
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge sim_clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= model_reset();
            m_sprev <= 1'b0;
            m_jprev <= 1'b0;
        end else begin
            m <= model_next(m, bus.frame_tick, bus.start_btn & ~m_sprev, bus.jump_btn & ~m_jprev,
                            bus.player_state[21:12] >= 10'd515, bus.goal_hit);
            m_sprev <= bus.start_btn;
            m_jprev <= bus.jump_btn;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge sim_clk) begin
        chk("model.game_state", {29'd0, bus.game_state}, m.state);
        chk("model.level", {30'd0, bus.level}, m.level);
        chk("model.lives", {30'd0, bus.lives}, m.lives);
        chk("model.player_step", {31'd0, bus.player_step}, {31'd0, m.step});
        chk("model.init_state", bus.init_state,
            {10'd176, 10'd99, 5'(4 + m.level), 5'd0, 1'b1, 1'b0});
        if (m.step || m.state == 0) chk("model.player_load", {31'd0, bus.player_load}, {31'd0, m.load});
        if (m.step) chk("model.jump_r", {31'd0, bus.jump_r}, {31'd0, m.jump});
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sim_clk);
    endtask

    task automatic tick(output logic st, output logic ld, output logic jr);
        @(negedge sim_clk);
        bus.frame_tick = 1'b1;
        @(negedge sim_clk);
        bus.frame_tick = 1'b0;
        st = bus.player_step;
        ld = bus.player_load;
        jr = bus.jump_r;
    endtask

    task automatic ticks(input int n);
        logic st, ld, jr;
        repeat (n) tick(st, ld, jr);
    endtask

    task automatic press_start();
        @(negedge sim_clk);
        bus.start_btn = 1'b1;
        @(negedge sim_clk);
        bus.start_btn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic st, ld, jr;
        reset_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start_btn = 1'b0;
        bus.jump_btn = 1'b0;
        bus.goal_hit = 1'b0;
        bus.player_state = ALIVE_STATE;
        idle(2);
        chk("reset.game_state", {29'd0, bus.game_state}, 32'd0);
        chk("reset.lives", {30'd0, bus.lives}, 32'd3);
        chk("reset.load", {31'd0, bus.player_load}, 32'd1);
        chk("reset.init_state", bus.init_state, 32'h2C06_3202);
        reset_n = 1'b1;
        idle(2);

        // start, one load step, then two ordinary steps
        press_start();
        idle(1);
        chk("start.to_load", {29'd0, bus.game_state}, 32'd1);
        tick(st, ld, jr);
        chk("loadstep.step", {31'd0, st}, 32'd1);
        chk("loadstep.load", {31'd0, ld}, 32'd1);
        chk("loadstep.jump", {31'd0, jr}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(st, ld, jr);
            chk("play.step", {31'd0, st}, 32'd1);
            chk("play.load", {31'd0, ld}, 32'd0);
        end

        // held jump yields one request
        @(negedge sim_clk);
        bus.jump_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(st, ld, jr);
            chk("jump.held", {31'd0, jr}, (i == 0) ? 32'd1 : 32'd0);
        end
        bus.jump_btn = 1'b0;

        // jump edge coincident with a step is carried to the next step
        @(negedge sim_clk);
        bus.frame_tick = 1'b1;
        bus.jump_btn = 1'b1;
        @(negedge sim_clk);
        bus.frame_tick = 1'b0;
        bus.jump_btn = 1'b0;
        chk("jump.coincident_now", {31'd0, jr & 1'b0 | bus.jump_r}, 32'd0);
        tick(st, ld, jr);
        chk("jump.coincident_next", {31'd0, jr}, 32'd1);

        // yPos 514 is still alive; 515 with goal_hit is death
        bus.player_state = {10'd176, 10'd514, 12'd0};
        tick(st, ld, jr);
        chk("ypos514.step", {31'd0, st}, 32'd1);
        bus.player_state = {10'd176, 10'd515, 12'd0};
        bus.goal_hit = 1'b1;
        tick(st, ld, jr);
        chk("death.no_step", {31'd0, st}, 32'd0);
        chk("death.state", {29'd0, bus.game_state}, 32'd3);
        bus.goal_hit = 1'b0;
        bus.player_state = ALIVE_STATE;
        press_start();
        idle(1);
        chk("death.start_ignored", {29'd0, bus.game_state}, 32'd3);
        ticks(59);
        chk("freeze59.state", {29'd0, bus.game_state}, 32'd3);
        ticks(1);
        chk("freeze60.state", {29'd0, bus.game_state}, 32'd1);
        chk("freeze60.lives", {30'd0, bus.lives}, 32'd2);
        chk("freeze60.level", {30'd0, bus.level}, 32'd0);

        // clear levels 0..2, then level 3 wins
        for (int lv = 0; lv < 4; lv++) begin
            ticks(1);
            bus.goal_hit = 1'b1;
            tick(st, ld, jr);
            bus.goal_hit = 1'b0;
            chk("clear.no_step", {31'd0, st}, 32'd0);
            ticks(FREEZE);
            if (lv == 2) chk("level3.init_state", bus.init_state, 32'h2C06_3382);
        end
        chk("won.state", {29'd0, bus.game_state}, 32'd6);
        tick(st, ld, jr);
        chk("won.no_step", {31'd0, st}, 32'd0);
        press_start();
        idle(1);
        chk("restart.level", {30'd0, bus.level}, 32'd0);
        chk("restart.lives", {30'd0, bus.lives}, 32'd3);
        chk("restart.state", {29'd0, bus.game_state}, 32'd1);

        // lose all lives
        for (int k = 0; k < 3; k++) begin
            ticks(1);
            bus.player_state = {10'd176, 10'd600, 12'd0};
            ticks(1);
            bus.player_state = ALIVE_STATE;
            ticks(FREEZE);
        end
        chk("over.state", {29'd0, bus.game_state}, 32'd5);
        chk("over.lives", {30'd0, bus.lives}, 32'd0);
        tick(st, ld, jr);
        chk("over.no_step", {31'd0, st}, 32'd0);

        // asynchronous reset in the middle of a freeze
        press_start();
        ticks(1);
        bus.player_state = {10'd176, 10'd515, 12'd0};
        ticks(1);
        bus.player_state = ALIVE_STATE;
        ticks(10);
        chk("prereset.state", {29'd0, bus.game_state}, 32'd3);
        @(negedge sim_clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("asyncrst.state", {29'd0, bus.game_state}, 32'd0);
        chk("asyncrst.load", {31'd0, bus.player_load}, 32'd1);
        chk("asyncrst.step", {31'd0, bus.player_step}, 32'd0);
        chk("asyncrst.lives", {30'd0, bus.lives}, 32'd3);
        @(negedge sim_clk);
        reset_n = 1'b1;
        idle(3);
        chk("postreset.state", {29'd0, bus.game_state}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/player_sequencer.md
# player_sequencer

Frame-level controller for the player datapath. It converts the display's per-frame tick into single-cycle player update strobes, and it loads the per-level initial player state through the player's load/reset input. It also latches jump button presses so each press yields exactly one jump request. The game-flow state machine (title, play, death freeze, level clear, game over, win) sits between the input/VGA timing logic and the player/collision datapath.

## Interface
- NUM_LEVELS, 4, number of levels (1..4); level index wraps never, last level leads to WON
- LIVES, 3, lives at game start (1..3)
- DEATH_Y, 10'd515, yPos at or beyond which the player is dead
- FREEZE_FRAMES, 60, frames frozen after death or level clear (1..255)
- sim_clk  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  start button, synchronous level
- jump_btn  in  1  jump button, synchronous level
- goal_hit  in  1  player overlaps goal tile (from collision logic), level
- player_state  in  32  {xPos[31:22], yPos[21:12], xSpeed[11:7], ySpeed[6:2], xDir[1], yDir[0]}
- player_step  out  1  one-cycle player update strobe (player clock enable)
- player_load  out  1  player load/reset; player takes init_state when high on a step
- init_state  out  32  initial player state for current level, same packing
- jump_r  out  1  jump request, valid only while player_step is high
- level  out  2  current level index
- lives  out  2  remaining lives
- game_state  out  3  FSM state encoding

## Operation
- States and encoding: IDLE=0, LOAD=1, PLAY=2, DYING=3, CLEARED=4, OVER=5, WON=6. Encodings 7 and above go to IDLE.
- Reset values: game_state=IDLE, level=0, lives=LIVES, player_step=0, player_load=1, jump_r=0, freeze counter=0, jump latch=0, button edge registers=0. init_state holds the level-0 vector.
- init_state for level L: xPos=176, yPos=99, xSpeed=4+L, ySpeed=0, xDir=1 (right), yDir=0 (down). It is purely a function of level.
- Edge detection: start and jump act on rising edges only (registered previous value). A held button does not repeat.
- IDLE: player_load=1 and no steps. Start edge → LOAD.
- LOAD: waits for frame_tick. On that tick: player_step=1, player_load=1, jump_r=0 for one cycle, jump latch cleared, then → PLAY.
- PLAY: on each frame_tick the FSM checks, in priority order:
  - player_state yPos ≥ DEATH_Y → DYING, no step issued.
  - else goal_hit → CLEARED, no step issued.
  - else player_step=1, player_load=0, jump_r=jump latch; the latch clears on this cycle.
- Jump latch: set on a jump edge during PLAY. A jump edge on the same cycle as the consuming step stays latched for the next step. The latch is forced to 0 outside PLAY.
- DYING: the freeze counter increments per frame_tick. When the count reaches FREEZE_FRAMES, the counter clears and lives decrements.
  - If lives was 1 → OVER, with lives=0.
  - Otherwise → LOAD (same level).
- CLEARED: same freeze. Then if level=NUM_LEVELS-1 → WON, else level+1 and → LOAD.
- OVER / WON: no steps. Start edge → level=0, lives=LIVES, → LOAD.
- Start edges in LOAD, PLAY, DYING and CLEARED are ignored.
- Arithmetic: yPos compare is unsigned 10-bit. The freeze counter is 8-bit. lives never underflows.

## Timing
- All outputs are registered. A frame_tick in cycle N produces player_step/player_load/jump_r in cycle N+1, for exactly one cycle.
- The PLAY decision uses player_state and goal_hit sampled in cycle N.
- At most one player_step per frame_tick. frame_tick pulses closer than 2 cycles apart are not supported.
- Async reset mid-operation: outputs reach reset values immediately. player_load=1 holds the player in its initial state until the next LOAD step.
- A frame_tick arriving on the same cycle as a state transition is evaluated in the old state.

## Test plan
- Reset, then a start edge, then 3 frame_ticks → one load step (player_load=1, jump_r=0), then 2 steps with player_load=0. init_state xSpeed=4, xPos=176, yPos=99.
- In PLAY, jump_btn held high across 5 frames → jump_r=1 on the first following step only. A second edge coincident with a step → jump_r=1 on the next step.
- In PLAY, set player_state yPos=515 with goal_hit=1 → DYING (death wins), no step. After 60 ticks: lives 3→2, LOAD, level unchanged.
- goal_hit=1 at level 3 → CLEARED, then after 60 ticks → WON. A start edge then gives level=0, lives=3, LOAD.
- Lose all 3 lives → OVER with lives=0. Steps stop, and start edges during DYING are ignored.
- Assert reset_n low mid-freeze → game_state=IDLE, player_load=1, player_step=0 on the same cycle, without any clock edge.
